// File: rtl/key_press_conditioner.sv
// Player key input stage: synchronise, debounce and edge-detect keyL/keyR into
// one-cycle L/R pulses, one per physical press.
module key_press_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic Clock,
   input  logic Reset,
   input  logic keyL,
   input  logic keyR,
   input  logic enable,
   output logic L,
   output logic R
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned NUM_KEYS = 2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } state_t;

   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] key_pressed;
   logic [NUM_KEYS-1:0] pulse_vec;

   // Bit 0 is the left player, bit 1 the right; 1 = pressed after polarity fix.
   assign key_raw     = {keyR, keyL};
   assign key_pressed = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

   for (genvar ch = 0; ch < NUM_KEYS; ch++) begin : g_chan
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic             sync_meta;
      logic             sync_s;
      logic             pulse;

      // Reset parks the FSM in HELD so a key held across reset release is not a press.
      always_ff @(posedge Clock or negedge Reset) begin
         if (!Reset) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
            state     <= HELD;
            cnt       <= '0;
            pulse     <= 1'b0;
         end else begin
            sync_meta <= key_pressed[ch];
            sync_s    <= sync_meta;
            pulse     <= 1'b0;
            case (state)
               IDLE: begin
                  if (sync_s) begin
                     state <= PRESS_WAIT;
                     cnt   <= CNT_W'(1);
                  end
               end
               PRESS_WAIT: begin
                  if (!sync_s) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                     state <= HELD;
                     pulse <= enable;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               HELD: begin
                  if (!sync_s) begin
                     state <= REL_WAIT;
                     cnt   <= CNT_W'(1);
                  end
               end
               REL_WAIT: begin
                  if (sync_s) begin
                     state <= HELD;
                  end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign pulse_vec[ch] = pulse;
   end

   assign L = pulse_vec[0];
   assign R = pulse_vec[1];

endmodule

// File: tb/tb_key_press_conditioner.sv
// Scoreboard bench for key_press_conditioner: expected pulses are queued when
// a press is driven and matched against L/R on every falling clock edge.
module tb_key_press_conditioner;

   localparam int DEB = 4;

   typedef struct {
      int   cyc;
      logic l;
      logic r;
   } sb_entry_t;

   logic Clock;
   logic Reset;
   logic keyL;
   logic keyR;
   logic enable;
   logic L;
   logic R;

   int        cyc = 0;
   int        n_tests = 0;
   int        n_fail = 0;
   int        target;
   sb_entry_t sb[$];

   key_press_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .KEY_ACTIVE_LOW (1'b1)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .keyL  (keyL),
      .keyR  (keyR),
      .enable(enable),
      .L     (L),
      .R     (R)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clock);
   endtask

   // A press driven now is sampled on the next edge and pulses DEB+1 edges later.
   task automatic expect_pulse(input logic l, input logic r);
      sb_entry_t e;
      e.cyc = cyc + DEB + 2;
      e.l   = l;
      e.r   = r;
      sb.push_back(e);
   endtask

   // Output monitor: any pulse must match the queue head for this cycle.
   always @(negedge Clock) begin
      sb_entry_t e;
      logic      hit;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         check("missing_pulse_cyc", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      hit   = (sb.size() > 0) && (sb[0].cyc == cyc);
      e.cyc = cyc;
      e.l   = 1'b0;
      e.r   = 1'b0;
      if (hit) begin
         e = sb[0];
         void'(sb.pop_front());
      end
      if (hit || L || R) begin
         check("pulse_L", 32'(L), 32'(e.l));
         check("pulse_R", 32'(R), 32'(e.r));
      end
   end

   initial begin
      keyL   = 1'b1;
      keyR   = 1'b1;
      enable = 1'b1;
      Reset  = 1'b1;
      #1 Reset = 1'b0;
      tick(3);
      check("reset_L", 32'(L), 32'd0);
      check("reset_R", 32'(R), 32'd0);
      Reset = 1'b1;
      tick(8);

      // Basic right press, held long
      keyR = 1'b0;
      expect_pulse(1'b0, 1'b1);
      tick(12);
      keyR = 1'b1;
      tick(8);

      // Left bounce shorter than the debounce window
      keyL = 1'b0;
      tick(3);
      keyL = 1'b1;
      tick(8);

      // Left press with a short release glitch mid-hold, then a clean re-press
      keyL = 1'b0;
      expect_pulse(1'b1, 1'b0);
      tick(8);
      keyL = 1'b1;
      tick(2);
      keyL = 1'b0;
      tick(10);
      keyL = 1'b1;
      tick(8);
      keyL = 1'b0;
      expect_pulse(1'b1, 1'b0);
      tick(8);
      keyL = 1'b1;
      tick(8);

      // Simultaneous presses
      keyL = 1'b0;
      keyR = 1'b0;
      expect_pulse(1'b1, 1'b1);
      tick(10);
      keyL = 1'b1;
      keyR = 1'b1;
      tick(8);

      // Press while disabled is consumed; raising enable mid-hold issues nothing
      enable = 1'b0;
      keyR   = 1'b0;
      tick(10);
      enable = 1'b1;
      tick(5);
      keyR = 1'b1;
      tick(6);
      keyR = 1'b0;
      expect_pulse(1'b0, 1'b1);
      tick(8);
      keyR = 1'b1;
      tick(8);

      // Reset while a pulse is high clears it immediately
      keyR = 1'b0;
      expect_pulse(1'b0, 1'b1);
      target = cyc + DEB + 2;
      for (int i = 0; i < DEB + 2 && cyc != target; i++) tick(1);
      #1 Reset = 1'b0;
      keyR = 1'b1;
      #1 check("reset_async_R", 32'(R), 32'd0);
      tick(2);
      Reset = 1'b1;
      tick(8);

      // Reset mid-debounce with the key held through reset release
      keyL = 1'b0;
      tick(3);
      #1 Reset = 1'b0;
      #1 check("reset_mid_L", 32'(L), 32'd0);
      check("reset_mid_R", 32'(R), 32'd0);
      tick(2);
      Reset = 1'b1;
      tick(20);
      keyL = 1'b1;
      tick(6);
      keyL = 1'b0;
      expect_pulse(1'b1, 1'b0);
      tick(8);
      keyL = 1'b1;
      tick(8);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
